// File: rtl/ram_clear_pkg.sv
// ram_clear_pkg
// Shared definitions for the RAM-clear sequencer.
//   state_t    : sequencer states
//   BURSTCNT_W : width of the Avalon burstcount field
//   FILL_BIT   : bit replicated to build the default fill pattern
package ram_clear_pkg;

  localparam int BURSTCNT_W = 8;

  localparam logic FILL_BIT = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELAY,
    ST_BURST,
    ST_GAP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ram_clear.sv
// ram_clear
// Fills a programmable word range with a constant pattern through an
// Avalon-style burst write port so a core starts with known RAM contents.
//
// Ports:
//   clk_sys   in   system clock
//   reset_n   in   asynchronous active-low reset
//   start     in   one-cycle request to begin a clear (IDLE/DONE only)
//   base_addr in   first word address, sampled on start
//   length    in   number of words (AW+1 bits, full 2^AW range legal)
//   busy      in   memory stall; a beat is accepted when we & ~busy
//   addr      out  burst start address
//   din       out  write data, always FILL
//   be        out  byte enables, all ones
//   burstcnt  out  beats in the current burst
//   we        out  write request
//   active    out  clear in progress
//   done      out  last clear completed, cleared on start
module ram_clear
  import ram_clear_pkg::*;
#(
  parameter int              AW          = 25,
  parameter int              DW          = 64,
  parameter int              BURST       = 8,
  parameter int              GAP         = 0,
  parameter int              START_DELAY = 5000000,
  parameter logic [DW-1:0]   FILL        = {DW{FILL_BIT}},
  parameter bit              AUTO        = 1'b1
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [AW-1:0]         base_addr,
  input  logic [AW:0]           length,
  input  logic                  busy,
  output logic [AW-1:0]         addr,
  output logic [DW-1:0]         din,
  output logic [DW/8-1:0]       be,
  output logic [BURSTCNT_W-1:0] burstcnt,
  output logic                  we,
  output logic                  active,
  output logic                  done
);

  // Counters are preloaded with N-1 and exit on zero, so DELAY lasts
  // START_DELAY cycles and GAP lasts GAP cycles.
  localparam logic [31:0]         DLY_LOAD  = (START_DELAY > 0) ? 32'(START_DELAY - 1) : 32'd0;
  localparam logic [7:0]          GAP_LOAD  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
  localparam logic [AW:0]         BURST_MAX = (AW + 1)'(BURST);
  localparam logic [BURSTCNT_W-1:0] BURST_CNT = BURSTCNT_W'(BURST);

  // min(BURST, remaining); when remaining < BURST it fits in BURSTCNT_W.
  function automatic logic [BURSTCNT_W-1:0] burst_len(input logic [AW:0] rem);
    if (rem < BURST_MAX)
      burst_len = BURSTCNT_W'(rem);
    else
      burst_len = BURST_CNT;
  endfunction

  state_t                r_state;
  logic [AW-1:0]         r_addr;
  logic [AW:0]           r_rem;
  logic [BURSTCNT_W-1:0] r_beats;
  logic [BURSTCNT_W-1:0] r_burstcnt;
  logic [31:0]           r_dly;
  logic [7:0]            r_gap;
  logic                  r_we;
  logic                  r_active;
  logic                  r_done;
  logic                  r_auto;

  logic                  w_beat;
  logic [AW:0]           w_rem_dec;
  logic [BURSTCNT_W-1:0] w_first_cnt;
  logic [BURSTCNT_W-1:0] w_next_cnt;

  assign w_beat      = r_we & ~busy;
  assign w_rem_dec   = r_rem - 1'b1;
  assign w_first_cnt = burst_len(r_rem);
  // Size of the burst that follows back-to-back, based on the count left
  // after the beat being accepted this cycle.
  assign w_next_cnt  = burst_len(w_rem_dec);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_rem      <= '0;
      r_beats    <= '0;
      r_burstcnt <= '0;
      r_dly      <= '0;
      r_gap      <= '0;
      r_we       <= 1'b0;
      r_active   <= 1'b0;
      r_done     <= 1'b0;
      // A pending auto-start is consumed on the first clock edge.
      r_auto     <= AUTO;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start || r_auto) begin
            r_auto   <= 1'b0;
            r_addr   <= base_addr;
            r_rem    <= length;
            r_dly    <= DLY_LOAD;
            r_done   <= 1'b0;
            r_active <= 1'b1;
            r_state  <= ST_DELAY;
          end
        end

        ST_DELAY: begin
          if (r_dly == '0) begin
            if (r_rem == '0) begin
              r_active <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= ST_DONE;
            end else begin
              r_burstcnt <= w_first_cnt;
              r_beats    <= w_first_cnt;
              r_we       <= 1'b1;
              r_state    <= ST_BURST;
            end
          end else begin
            r_dly <= r_dly - 1'b1;
          end
        end

        ST_BURST: begin
          // addr/burstcnt/we stay frozen while busy holds the beat off.
          if (w_beat) begin
            r_rem <= w_rem_dec;
            if (r_beats == BURSTCNT_W'(1)) begin
              r_addr <= r_addr + AW'(r_burstcnt);
              if (w_rem_dec == '0) begin
                r_we     <= 1'b0;
                r_active <= 1'b0;
                r_done   <= 1'b1;
                r_state  <= ST_DONE;
              end else if (GAP > 0) begin
                r_we    <= 1'b0;
                r_gap   <= GAP_LOAD;
                r_state <= ST_GAP;
              end else begin
                // Back-to-back: we stays high into the next burst.
                r_burstcnt <= w_next_cnt;
                r_beats    <= w_next_cnt;
              end
            end else begin
              r_beats <= r_beats - 1'b1;
            end
          end
        end

        ST_GAP: begin
          if (r_gap == '0) begin
            r_burstcnt <= w_first_cnt;
            r_beats    <= w_first_cnt;
            r_we       <= 1'b1;
            r_state    <= ST_BURST;
          end else begin
            r_gap <= r_gap - 1'b1;
          end
        end

        default: begin
          r_we     <= 1'b0;
          r_active <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign addr     = r_addr;
  assign din      = FILL;
  assign be       = '1;
  assign burstcnt = r_burstcnt;
  assign we       = r_we;
  assign active   = r_active;
  assign done     = r_done;

endmodule

// File: doc/ram_clear.md
# ram_clear

Parametrised RAM-clear sequencer for the menu core, with both SDRAM and DDR3 ports instanced on `clk_sys`. It fills a programmable word range with a constant pattern through an Avalon-style burst write port, so cores start with known RAM contents. It generalises the fixed one-write-per-32-cycles clear loop with:
- configurable widths, burst length and pacing;
- a `busy` handshake;
- restart and completion status.

## Interface
Parameters:
- `AW`, 25: word address width.
- `DW`, 64: data width.
- `BURST`, 8: maximum beats per burst, 1..255.
- `GAP`, 0: idle cycles between bursts, 0..255.
- `START_DELAY`, 5000000: cycles to wait after start before the first write.
- `FILL`, `{DW{1'b0}}`: fill pattern.
- `AUTO`, 1: start automatically after reset using `base_addr`/`length` as sampled on the first clock edge.

Ports:
- `clk_sys`, in, 1: system clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle request to begin a clear.
- `base_addr`, in, AW: first word address; sampled on start.
- `length`, in, AW+1: number of words; sampled on start.
- `busy`, in, 1: memory stall. A beat is accepted when `we & ~busy`.
- `addr`, out, AW: burst start address.
- `din`, out, DW: write data, always `FILL`.
- `be`, out, DW/8: byte enables, all ones.
- `burstcnt`, out, 8: beats in the current burst.
- `we`, out, 1: write request.
- `active`, out, 1: clear in progress.
- `done`, out, 1: last clear completed. Cleared on start.

## Operation
States (enum): IDLE, DELAY, BURST, GAP, DONE.

Start handling:
- In IDLE or DONE, `start` (or the first cycle after reset when `AUTO`=1) latches `base_addr` and `length`.
- It then clears `done` and enters DELAY.
- `start` in DELAY, BURST or GAP is ignored.

DELAY:
- Counts `START_DELAY` cycles, then enters BURST.
- If `length`==0, goes to DONE instead, with no writes.

BURST:
- Issues `burstcnt = min(BURST, remaining)` at the current address.
- `we`, `addr`, `burstcnt` are held stable until the last beat is accepted.
- Each accepted beat decrements the beat and remaining counters.

After the last beat of a burst:
- `addr` advances by `burstcnt`; the address counter is AW bits and wraps modulo 2^AW.
- If remaining==0: go to DONE.
- Else if `GAP`>0: go to GAP for `GAP` cycles, then BURST.
- Else: go directly to BURST. The next burst's `we` is high in the very next cycle, so `we` stays high continuously.

DONE:
- `done`=1, `active`=0, `we`=0 until the next start.

Status and widths:
- `active` = state is DELAY, BURST or GAP.
- All arithmetic is unsigned.
- The remaining counter is AW+1 bits, so a full 2^AW range is legal.

## Timing
Reset values (immediate on `reset_n` low, any state, mid-burst included):
- `we`=0, `addr`=0, `burstcnt`=0, `active`=0, `done`=0.
- State is IDLE; counters are 0.

Start-to-write latency:
- `start` sampled at edge 0 → `active`=1 from edge 1.
- First `we` at edge `START_DELAY`+1.

Beats and bursts:
- One beat per cycle while `busy`=0.
- `busy`=1 stalls with all outputs frozen.
- Burst length 1 is legal.
- Burst-to-burst spacing: `GAP` cycles of `we`=0.

Completion:
- `done` rises one edge after the final accepted beat, together with `we` falling.
- A `start` in the same cycle as that final beat is ignored.
- A `start` in the first DONE cycle is honoured.

## Structure
- `ram_clear_pkg`: state enum typedef, `FILL` default, the 8-bit `burstcnt` width constant.
- Single module, no sub-modules.
- One instance per memory: SDRAM with `DW`=16, `BURST`=1; DDR3 with `DW`=64, `BURST`=8.

## Test plan
- `AUTO`=1, `START_DELAY`=4, `length`=16, `BURST`=8, `GAP`=0, `busy`=0:
  - first `we` at cycle 5;
  - bursts at `addr` 0 and 8;
  - `we` continuous for 16 cycles;
  - `done` at cycle 21.
- `length`=10, `BURST`=4, `GAP`=2: bursts (addr, cnt) = (0,4), (4,4), (8,2), with 2 idle cycles between bursts; `done` after 10 beats.
- `busy` toggled pseudo-randomly during a burst: `addr` and `burstcnt` stay stable; exactly `length` beats are accepted; no beat is lost or duplicated.
- `base_addr`=2^AW-3, `length`=6, `BURST`=8: a single burst of 6; address wrap is reflected on the next clear's `addr` start (0x3 if chained).
- `length`=0 → DONE after the delay with no `we`.
- `start` during BURST is ignored.
- `reset_n` pulsed low mid-burst: `we` drops asynchronously; outputs return to reset values; `AUTO` restart repeats the full sequence.
